// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, ROM address, IF/ID register
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  input  logic        hold_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        if_valid_o,
  output logic        misalign_o,
  output logic [31:0] fetch_cnt_o
);

  logic [31:0] pc;
  logic        run;

  // RUN only when neither a redirect nor a stall is active; jump outranks hold
  assign run         = !jump_en_i && !hold_i;
  assign inst_addr_o = pc;

  // program counter: redirect to word-aligned target, freeze on hold, else advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (jump_en_i) begin
      pc <= {jump_addr_i[31:2], 2'b00};
    end else if (!hold_i) begin
      pc <= pc + 32'd4;
    end
  end

  // IF/ID register: flush to a bubble on redirect, hold on stall, capture ROM word on run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_inst_o  <= NOP_INST;
      if_pc_o    <= 32'd0;
      if_valid_o <= 1'b0;
    end else if (jump_en_i) begin
      if_inst_o  <= NOP_INST;
      if_pc_o    <= 32'd0;
      if_valid_o <= 1'b0;
    end else if (!hold_i) begin
      if_inst_o  <= inst_i;
      if_pc_o    <= pc;
      if_valid_o <= 1'b1;
    end
  end

  // misalign pulse lasts one cycle: set only on the edge that accepts the jump
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= jump_en_i && (jump_addr_i[1:0] != 2'b00);
    end
  end

  // delivered-instruction counter, saturating so it never wraps back to small values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_o <= 32'd0;
    end else if (run && (fetch_cnt_o != 32'hFFFF_FFFF)) begin
      fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end

endmodule
